// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio sample types and constants for the output stage
package audio_pkg;
  localparam int SAMPLE_W    = 16;
  localparam int FRAME_SLOTS = 32;
  localparam int SAMPLE_MAX  = 32767;
  localparam int SAMPLE_MIN  = -32768;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic {
    PRIME = 1'b0,
    RUN   = 1'b1
  } tx_state_t;
endpackage

// File: rtl/sat_to_sample.sv
// rtl/sat_to_sample.sv - combinational signed IN_W to 16-bit saturator with clip flag
module sat_to_sample
  import audio_pkg::*;
#(
  parameter int IN_W = 32
) (
  input  logic [IN_W-1:0] din_i,
  output sample_t         value_o,
  output logic            clipped_o
);

  // In range exactly when every bit from the top down to bit 15 matches the sign
  logic [IN_W-SAMPLE_W:0] hi;
  assign hi = din_i[IN_W-1:SAMPLE_W-1];

  always_comb begin
    clipped_o = !((&hi) || !(|hi));
    value_o   = din_i[SAMPLE_W-1:0];
    if (clipped_o) begin
      value_o = din_i[IN_W-1] ? sample_t'(SAMPLE_MIN) : sample_t'(SAMPLE_MAX);
    end
  end

endmodule

// File: rtl/i2s_tx_sat.sv
// rtl/i2s_tx_sat.sv - saturating one-entry buffered mono-duplicated Philips I2S transmitter
module i2s_tx_sat
  import audio_pkg::*;
#(
  parameter int BCLK_DIV = 16,
  parameter int IN_W     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [IN_W-1:0] sample_in,
  input  logic            sample_valid,
  output logic            sample_ready,
  output logic            bclk,
  output logic            lrclk,
  output logic            sdata,
  output logic            clip,
  output logic            underrun
);

  localparam int DIV_W  = $clog2(BCLK_DIV);
  localparam int SLOT_W = $clog2(FRAME_SLOTS);

  logic [DIV_W-1:0]  div_q, div_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic              bclk_q, bclk_d;
  logic              lrclk_q, lrclk_d;
  logic              sdata_q, sdata_d;
  logic              clip_q, clip_d;
  logic              underrun_q, underrun_d;
  sample_t           buf_q, buf_d;
  logic              buf_full_q, buf_full_d;
  sample_t           shreg_q, shreg_d;
  tx_state_t         state_q, state_d;

  sample_t    sat_value;
  logic       sat_clipped;
  logic       accept;
  logic       fall;
  logic [3:0] bit_idx;

  sat_to_sample #(.IN_W(IN_W)) u_sat (
    .din_i     (sample_in),
    .value_o   (sat_value),
    .clipped_o (sat_clipped)
  );

  assign accept = sample_valid && !buf_full_q;

  always_comb begin
    div_d      = div_q + 1'b1;
    bclk_d     = bclk_q;
    slot_d     = slot_q;
    lrclk_d    = lrclk_q;
    sdata_d    = sdata_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    shreg_d    = shreg_q;
    state_d    = state_q;
    clip_d     = 1'b0;
    underrun_d = 1'b0;
    fall       = 1'b0;
    bit_idx    = 4'd0;

    if (div_q == DIV_W'(BCLK_DIV - 1)) begin
      div_d  = '0;
      bclk_d = !bclk_q;
      fall   = bclk_q;
    end

    if (fall) begin
      slot_d  = slot_q + 1'b1;
      lrclk_d = slot_d[SLOT_W-1];
      // Entering slot 1 is the consume point; the pre-edge buffer state decides
      if (slot_q == '0) begin
        if (buf_full_q) begin
          shreg_d    = buf_q;
          buf_full_d = 1'b0;
          state_d    = RUN;
        end else if (state_q == RUN) begin
          underrun_d = 1'b1;
        end
      end
      // Slot s carries bit (16 - s) mod 16, giving the one-bclk delay per half-frame
      bit_idx = 4'd0 - slot_d[3:0];
      sdata_d = shreg_d[bit_idx];
    end

    if (accept) begin
      buf_d      = sat_value;
      buf_full_d = 1'b1;
      clip_d     = sat_clipped;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q      <= '0;
      slot_q     <= '0;
      bclk_q     <= 1'b0;
      lrclk_q    <= 1'b0;
      sdata_q    <= 1'b0;
      clip_q     <= 1'b0;
      underrun_q <= 1'b0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      shreg_q    <= '0;
      state_q    <= PRIME;
    end else begin
      div_q      <= div_d;
      slot_q     <= slot_d;
      bclk_q     <= bclk_d;
      lrclk_q    <= lrclk_d;
      sdata_q    <= sdata_d;
      clip_q     <= clip_d;
      underrun_q <= underrun_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      shreg_q    <= shreg_d;
      state_q    <= state_d;
    end
  end

  assign sample_ready = !buf_full_q;
  assign bclk         = bclk_q;
  assign lrclk        = lrclk_q;
  assign sdata        = sdata_q;
  assign clip         = clip_q;
  assign underrun     = underrun_q;

endmodule

// File: tb/tb_i2s_tx_sat.sv
// tb/tb_i2s_tx_sat.sv - self-checking bench for i2s_tx_sat against a cycle-count reference model
module tb_i2s_tx_sat;

  localparam int D  = 2;
  localparam int FR = 64 * D;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready, bclk, lrclk, sdata, clip, underrun;

  i2s_tx_sat #(.BCLK_DIV(D), .IN_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .bclk         (bclk),
    .lrclk        (lrclk),
    .sdata        (sdata),
    .clip         (clip),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] din;
    logic [15:0] word;
    bit          clipped;
  } vec_t;

  vec_t tbl [10];

  int          checks = 0;
  int          errors = 0;
  int          n;
  logic [15:0] q [$];
  logic [15:0] cur_word;
  bit          running;
  bit          m_fall, m_consumed;
  int          m_slot;
  logic [5:0]  expv;
  logic [15:0] cap;
  bit          cap_done;
  int          under_cnt, lr_toggles;
  logic        lr_prev;

  function automatic logic [15:0] sat16(input logic [31:0] x, output bit c);
    int v;
    v = $signed(x);
    c = 1'b1;
    if (v > 32767) return 16'h7fff;
    if (v < -32768) return 16'h8000;
    c = 1'b0;
    return x[15:0];
  endfunction

  function automatic logic [31:0] rand_sample();
    logic [31:0] r;
    r = $urandom;
    case (r[31:30])
      2'd0:    return {{16{r[15]}}, r[15:0]};
      2'd1:    return {{15{r[29]}}, r[16:0]};
      default: return r;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic model_reset();
    n = 0;
    q.delete();
    cur_word = '0;
    running = 1'b0;
    m_fall = 1'b0;
    m_consumed = 1'b0;
    m_slot = 0;
  endtask

  // Expected outputs after edge n, derived from elapsed-cycle arithmetic
  task automatic model_edge(input logic v, input logic [31:0] d);
    bit          was_empty, c, ur, cl;
    logic [15:0] s;
    int          k, b;
    n++;
    was_empty = (q.size() == 0);
    m_fall = (n % (2 * D)) == 0;
    k = n / (2 * D);
    m_slot = k % 32;
    m_consumed = 1'b0;
    ur = 1'b0;
    cl = 1'b0;
    if (m_fall && m_slot == 1) begin
      if (q.size() > 0) begin
        cur_word = q.pop_front();
        running = 1'b1;
        m_consumed = 1'b1;
      end else if (running) begin
        ur = 1'b1;
      end
    end
    if (v && was_empty) begin
      s = sat16(d, c);
      q.push_back(s);
      cl = c;
    end
    if (m_slot >= 1 && m_slot <= 16) b = 16 - m_slot;
    else if (m_slot >= 17) b = 32 - m_slot;
    else b = 0;
    expv = {((n / D) % 2) == 1, m_slot >= 16, cur_word[b], q.size() == 0, cl, ur};
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(sample_valid, sample_in);
    @(negedge clk);
    check($sformatf("outputs@%0d", n), {26'd0, bclk, lrclk, sdata, sample_ready, clip, underrun},
          {26'd0, expv});
    if (underrun) under_cnt++;
    if (lrclk !== lr_prev) lr_toggles++;
    lr_prev = lrclk;
    if (m_fall && m_slot >= 1 && m_slot <= 16) begin
      cap = {cap[14:0], sdata};
      if (m_slot == 16) cap_done = 1'b1;
    end
  endtask

  initial begin
    int t, acc;
    tbl[0] = '{32'h0000_1234, 16'h1234, 1'b0};
    tbl[1] = '{32'h0001_0000, 16'h7fff, 1'b1};
    tbl[2] = '{32'hfffe_0000, 16'h8000, 1'b1};
    tbl[3] = '{32'h0000_7fff, 16'h7fff, 1'b0};
    tbl[4] = '{32'hffff_8000, 16'h8000, 1'b0};
    tbl[5] = '{32'h0000_8000, 16'h7fff, 1'b1};
    tbl[6] = '{32'hffff_7fff, 16'h8000, 1'b1};
    tbl[7] = '{32'h7fff_ffff, 16'h7fff, 1'b1};
    tbl[8] = '{32'h8000_0000, 16'h8000, 1'b1};
    tbl[9] = '{32'hffff_ffff, 16'hffff, 1'b0};

    model_reset();
    cap = '0;
    cap_done = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {26'd0, bclk, lrclk, sdata, sample_ready, clip, underrun}, 32'h4);
    rst_n = 1'b1;
    lr_prev = 1'b0;
    under_cnt = 0;
    lr_toggles = 0;

    repeat (2 * FR) step();
    check("idle_lr_toggles", lr_toggles, 4);
    check("idle_underrun", under_cnt, 0);

    for (int i = 0; i < 10; i++) begin
      t = 0;
      while (!sample_ready && t < 4 * FR) begin step(); t++; end
      check($sformatf("ready_wait_%0d", i), {31'd0, sample_ready}, 32'd1);
      sample_in = tbl[i].din;
      sample_valid = 1'b1;
      step();
      sample_valid = 1'b0;
      sample_in = $urandom;
      check($sformatf("clip_%0d", i), {31'd0, clip}, {31'd0, tbl[i].clipped});
      t = 0;
      while (!m_consumed && t < 2 * FR) begin step(); t++; end
      check($sformatf("consumed_%0d", i), {31'd0, m_consumed}, 32'd1);
      cap_done = 1'b0;
      t = 0;
      while (!cap_done && t < 2 * FR) begin step(); t++; end
      check($sformatf("word_%0d", i), {16'd0, cap}, {16'd0, tbl[i].word});
    end

    under_cnt = 0;
    repeat (FR) step();
    check("underrun_once", under_cnt, 1);

    t = 0;
    while (!(m_fall && m_slot == 1) && t < 2 * FR) begin step(); t++; end
    check("found_consume_point", {31'd0, m_fall}, 32'd1);
    sample_valid = 1'b1;
    acc = 0;
    repeat (4 * FR) begin
      if (sample_ready) acc++;
      sample_in = rand_sample();
      step();
    end
    check("accepts_per_frame", acc, 4);

    repeat (3 * FR) begin
      sample_valid = ($urandom_range(0, 3) == 0);
      sample_in = rand_sample();
      step();
    end
    sample_valid = 1'b0;

    t = 0;
    while (!(m_fall && m_slot == 9) && t < 2 * FR) begin step(); t++; end
    check("found_slot9", {31'd0, m_fall}, 32'd1);
    step();
    #2 rst_n = 1'b0;
    #1 check("async_reset", {26'd0, bclk, lrclk, sdata, sample_ready, clip, underrun}, 32'h4);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    under_cnt = 0;
    repeat (2 * FR) step();
    check("post_reset_underrun", under_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_tx_sat.md
# i2s_tx_sat

Output stage directly downstream of the overdrive. It accepts the 32-bit signed overdrive result over a valid/ready handshake and saturates it to 16 bits. It then serialises the sample as a mono-duplicated stereo I2S stream (Philips format, 16 bits per slot) towards the codec DAC. The block generates its own bit clock and word-select from the system clock and flags clipping and underrun.

## Interface
- BCLK_DIV, 16: system clocks per bclk half-period (≥2); frame rate = f_clk / (64·BCLK_DIV).
- IN_W, 32: input sample width, signed two's complement.
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sample_in  in  IN_W  signed sample from the overdrive stage.
- sample_valid  in  1  sample_in is valid.
- sample_ready  out  1  one-entry input buffer is empty.
- bclk  out  1  I2S bit clock.
- lrclk  out  1  I2S word select; 0 = left, 1 = right.
- sdata  out  1  I2S serial data, MSB first.
- clip  out  1  one-cycle pulse: the accepted sample was saturated.
- underrun  out  1  one-cycle pulse: a frame started with the buffer empty (RUN only).

## Operation
- Saturation: sample_in > 32767 → 32767; sample_in < −32768 → −32768; otherwise sample_in[15:0].
- Saturation is applied on accept, and the saturated value is stored in the buffer.
- Handshake: transfer when sample_valid && sample_ready.
  - sample_ready = !buf_full.
  - sample_in is not required to be held after transfer.
- Divider: div_cnt counts 0..BCLK_DIV−1. At terminal count, bclk toggles and div_cnt wraps to 0.
- Falling-edge event (bclk 1→0): slot counter slot advances mod 32; lrclk = next slot[4].
- Consume point: the falling edge entering slot 1.
  - Buffer full: the word moves to the shift register and the buffer is cleared.
  - Buffer empty: the previous word is repeated.
- sdata per slot, for the current word W:
  - slots 1..16 carry W[15..0];
  - slots 17..31 carry W[15..1];
  - slot 0 of the next frame carries W[0].
  - This gives the one-bclk I2S delay after each lrclk edge.
- FSM states:
  - PRIME (after reset): word = 0, no underrun reported. Moves to RUN at the first consume point where the buffer is full.
  - RUN: an empty buffer at a consume point pulses underrun and repeats the last word.
  - RUN never returns to PRIME except through reset.
- Simultaneous accept and consume with buffer empty: the consume sees empty (underrun in RUN, or stays in PRIME). The new sample is stored and sample_ready falls next cycle.
- A full buffer cannot accept, so there is no overwrite case.
- clip pulses in the cycle after the accepting edge. It is independent of underrun.
- Reset mid-frame aborts the frame immediately. The partial word is discarded and no flags are raised.

## Timing
- Reset values:
  - bclk=0, lrclk=0, sdata=0, clip=0, underrun=0, sample_ready=1;
  - div_cnt=0, slot=0, word=0, buffer empty, state PRIME.
- All outputs are registered; sample_ready has no combinational path from sample_valid.
- bclk period = 2·BCLK_DIV clk. The first bclk rise is at the BCLK_DIV-th edge after reset release.
- lrclk and sdata change only in the cycle of a bclk falling event. They are stable across each bclk rise (codec samples on rise).
- Latency from accept to MSB on sdata: ≤ one frame + one slot, i.e. ≤ 66·BCLK_DIV clk.
- Throughput: one sample per frame; a sustained upstream rate above the frame rate back-pressures via sample_ready.
- underrun pulses in the cycle after the slot-1 falling event.

## Structure
- audio_pkg holds:
  - SAMPLE_W=16, FRAME_SLOTS=32, SAMPLE_MAX=32767, SAMPLE_MIN=−32768;
  - typedef sample_t (logic signed [15:0]);
  - enum tx_state_t {PRIME, RUN}.
- Sub-module sat_to_sample: combinational IN_W→16 saturator, outputs value and clipped flag. The overdrive clamp path can reuse it.
- The top level holds the divider, slot counter, buffer, shift register and FSM.

## Test plan
- Reset, then idle with BCLK_DIV=2:
  - bclk period 4 clk; lrclk toggles every 64 clk;
  - sdata=0 throughout; underrun never asserts (PRIME).
- Accept 0x0000_1234:
  - slots 1..16 carry 0001001000110100 and slots 17..31+0 repeat it;
  - clip=0; sample_ready re-asserts after the consume point.
- Accept 0x0001_0000:
  - transmitted word is 0x7FFF; clip pulses once.
- Accept 0xFFFE_0000:
  - transmitted word is 0x8000; clip pulses once.
- In RUN, withhold samples for one frame:
  - underrun pulses exactly once at the slot-1 event;
  - previous word is repeated.
- Hold sample_valid high continuously:
  - exactly one accept per frame; sample_ready low otherwise.
- Assert rst_n low mid-slot 9:
  - all outputs return to reset values asynchronously;
  - the next frame starts from slot 0 in PRIME.
